// File: rtl/sccomp_pkg.sv
// Shared constants and decode types for the single-cycle MIPS-subset core.
// Opcode/funct encodings, ALU and next-PC selectors, default reset PC.
package sccomp_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0040_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
        ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        NPC_SEQ, NPC_BR, NPC_JMP, NPC_JR
    } npc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_LINK
    } wb_sel_e;

endpackage

// File: rtl/sccomp_regfile.sv
// 32x32 register file: two async read ports, one sync write port.
// Asynchronous active-low clear; $0 reads as zero and ignores writes.
module sccomp_regfile
    import sccomp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] reg_16
);

    logic [31:0] array_reg [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) array_reg[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            array_reg[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : array_reg[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : array_reg[raddr2];
    assign reg_16 = array_reg[16];

endmodule

// File: rtl/sccomp_dataflow.sv
// Single-cycle MIPS-subset CPU: PC, ROM, decode, regfile, ALU, data RAM.
// The ROM starts as all zeros and is loaded through imem.memory.
module sccomp_dataflow
    import sccomp_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          DMEM_DEPTH = 1024,
    parameter string       IMEM_FILE  = "test.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_stall,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic [31:0] reg_16
);

    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    if (1) begin : imem
        logic [31:0] memory [IMEM_DEPTH] = '{default: '0};
    end

    logic [31:0] dmem [DMEM_DEPTH];

    logic [IW-1:0] imem_idx;
    assign imem_idx = IW'((pc - PC_RESET) >> 2);
    assign inst     = imem.memory[imem_idx];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] jidx;
    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign shamt = inst[10:6];
    assign funct = inst[5:0];
    assign imm   = inst[15:0];
    assign jidx  = inst[25:0];

    logic [31:0] rs_val, rt_val, wdata, alu_y, mem_rd;
    logic [31:0] imm_ext, pc_plus4, npc;
    logic [4:0]  waddr;
    logic [DW-1:0] dmem_idx;

    alu_op_e  alu_op;
    npc_sel_e npc_sel;
    wb_sel_e  wb_sel;
    logic     reg_we, mem_we, use_imm, zext, var_sh;

    always_comb begin
        alu_op  = ALU_ADD;
        npc_sel = NPC_SEQ;
        wb_sel  = WB_ALU;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        use_imm = 1'b0;
        zext    = 1'b0;
        var_sh  = 1'b0;
        waddr   = rt;
        case (op)
            OP_RTYPE: begin
                waddr  = rd;
                reg_we = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    FN_SLLV: begin alu_op = ALU_SLL; var_sh = 1'b1; end
                    FN_SRLV: begin alu_op = ALU_SRL; var_sh = 1'b1; end
                    FN_SRAV: begin alu_op = ALU_SRA; var_sh = 1'b1; end
                    FN_JR: begin
                        reg_we  = 1'b0;
                        npc_sel = NPC_JR;
                    end
                    default: reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                reg_we = 1'b1; use_imm = 1'b1;
            end
            OP_SLTI: begin
                reg_we = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT;
            end
            OP_SLTIU: begin
                reg_we = 1'b1; use_imm = 1'b1; alu_op = ALU_SLTU;
            end
            OP_ANDI: begin
                reg_we = 1'b1; use_imm = 1'b1; zext = 1'b1;
                alu_op = ALU_AND;
            end
            OP_ORI: begin
                reg_we = 1'b1; use_imm = 1'b1; zext = 1'b1;
                alu_op = ALU_OR;
            end
            OP_XORI: begin
                reg_we = 1'b1; use_imm = 1'b1; zext = 1'b1;
                alu_op = ALU_XOR;
            end
            OP_LUI: begin
                reg_we = 1'b1; alu_op = ALU_LUI;
            end
            OP_LW: begin
                reg_we = 1'b1; use_imm = 1'b1; wb_sel = WB_MEM;
            end
            OP_SW: begin
                mem_we = 1'b1; use_imm = 1'b1;
            end
            OP_BEQ: if (rs_val == rt_val) npc_sel = NPC_BR;
            OP_BNE: if (rs_val != rt_val) npc_sel = NPC_BR;
            OP_J:   npc_sel = NPC_JMP;
            OP_JAL: begin
                npc_sel = NPC_JMP;
                reg_we  = 1'b1;
                wb_sel  = WB_LINK;
                waddr   = 5'd31;
            end
            default: ;
        endcase
    end

    assign imm_ext = zext ? {16'h0, imm} : {{16{imm[15]}}, imm};

    logic [31:0] alu_a, alu_b;
    logic [4:0]  sa;
    assign alu_a = rs_val;
    assign alu_b = use_imm ? imm_ext : rt_val;
    assign sa    = var_sh ? rs_val[4:0] : shamt;

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD:  alu_y = alu_a + alu_b;
            ALU_SUB:  alu_y = alu_a - alu_b;
            ALU_AND:  alu_y = alu_a & alu_b;
            ALU_OR:   alu_y = alu_a | alu_b;
            ALU_XOR:  alu_y = alu_a ^ alu_b;
            ALU_NOR:  alu_y = ~(alu_a | alu_b);
            ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'd0, alu_a < alu_b};
            ALU_SLL:  alu_y = alu_b << sa;
            ALU_SRL:  alu_y = alu_b >> sa;
            ALU_SRA:  alu_y = $unsigned($signed(alu_b) >>> sa);
            ALU_LUI:  alu_y = {imm, 16'h0};
            default:  alu_y = '0;
        endcase
    end

    assign dmem_idx = DW'(alu_y >> 2);
    assign mem_rd   = dmem[dmem_idx];

    // Stores are gated by reset too, since the RAM itself is never cleared.
    always_ff @(posedge clk) begin
        if (reset && !cpu_stall && mem_we) dmem[dmem_idx] <= rt_val;
    end

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        wdata = alu_y;
        case (wb_sel)
            WB_MEM:  wdata = mem_rd;
            WB_LINK: wdata = pc_plus4;
            default: wdata = alu_y;
        endcase
    end

    always_comb begin
        npc = pc_plus4;
        case (npc_sel)
            NPC_BR:  npc = pc_plus4 + {imm_ext[29:0], 2'b00};
            NPC_JMP: npc = {pc_plus4[31:28], jidx, 2'b00};
            NPC_JR:  npc = rs_val;
            default: npc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          pc <= PC_RESET;
        else if (!cpu_stall) pc <= npc;
    end

    sccomp_regfile cpu_ref (
        .clk    (clk),
        .rst_n  (reset),
        .we     (reg_we && !cpu_stall),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rs_val),
        .rdata2 (rt_val),
        .reg_16 (reg_16)
    );

endmodule

// File: tb/tb_sccomp_dataflow.sv
// Directed-program bench for sccomp_dataflow.
// Programs are poked into imem.memory while reset is held low.
module tb_sccomp_dataflow;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_stall;
    logic [31:0] pc, inst, reg_16;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] prog [16];

    sccomp_dataflow dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_stall (cpu_stall),
        .pc        (pc),
        .inst      (inst),
        .reg_16    (reg_16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
    endtask

    task automatic load_and_start();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) dut.imem.memory[i] = 32'h0;
        for (int i = 0; i < 16; i++) dut.imem.memory[i] = prog[i];
        step(3);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] regs_or();
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) acc |= dut.cpu_ref.array_reg[i];
        return acc;
    endfunction

    initial begin
        reset     = 1'b0;
        cpu_stall = 1'b0;
        #1;

        // addiu / lui / sw / lw / read-before-write
        clear_prog();
        prog[0] = 32'h2410_0005;
        prog[1] = 32'h3C10_1234;
        prog[2] = 32'hAC10_0000;
        prog[3] = 32'h8C11_0000;
        prog[4] = 32'h2610_0001;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) dut.imem.memory[i] = 32'h0;
        for (int i = 0; i < 16; i++) dut.imem.memory[i] = prog[i];
        step(3);
        check("rst_pc", pc, 32'h0040_0000);
        check("rst_regs", regs_or(), 32'h0);
        check("rst_r16", reg_16, 32'h0);
        reset = 1'b1;
        #1;
        check("first_inst", inst, 32'h2410_0005);
        step(1);
        check("addiu_r16", reg_16, 32'h5);
        check("addiu_pc", pc, 32'h0040_0004);
        step(1);
        check("lui_r16", reg_16, 32'h1234_0000);
        check("lui_pc", pc, 32'h0040_0008);
        step(2);
        check("lw_r17", dut.cpu_ref.array_reg[17], 32'h1234_0000);
        step(1);
        check("rbw_r16", reg_16, 32'h1234_0001);

        // branches: beq taken, bne not taken, backward beq
        clear_prog();
        prog[0] = 32'h1000_0001;
        prog[2] = 32'h1400_0001;
        prog[3] = 32'h1000_FFFD;
        load_and_start();
        step(1);
        check("beq_pc", pc, 32'h0040_0008);
        step(1);
        check("bne_pc", pc, 32'h0040_000C);
        step(1);
        check("beq_back_pc", pc, 32'h0040_0004);

        // jal / jr / write to $0
        clear_prog();
        prog[0] = 32'h0C10_0004;
        prog[1] = 32'h2400_0007;
        prog[4] = 32'h03E0_0008;
        load_and_start();
        step(1);
        check("jal_pc", pc, 32'h0040_0010);
        check("jal_r31", dut.cpu_ref.array_reg[31], 32'h0040_0004);
        step(1);
        check("jr_pc", pc, 32'h0040_0004);
        step(1);
        check("r0_zero", dut.cpu_ref.array_reg[0], 32'h0);
        check("r0_pc", pc, 32'h0040_0008);

        // ALU coverage and an illegal opcode
        clear_prog();
        prog[0]  = 32'h2408_FFF8;
        prog[1]  = 32'h0008_8043;
        prog[2]  = 32'h0008_8102;
        prog[3]  = 32'h0100_802A;
        prog[4]  = 32'h0100_802B;
        prog[5]  = 32'h0008_8023;
        prog[6]  = 32'h0100_8027;
        prog[7]  = 32'h3410_8001;
        prog[8]  = 32'h3110_FFF0;
        prog[9]  = 32'hFC00_0000;
        load_and_start();
        step(2);
        check("sra", reg_16, 32'hFFFF_FFFC);
        step(1);
        check("srl", reg_16, 32'h0FFF_FFFF);
        step(1);
        check("slt", reg_16, 32'h1);
        step(1);
        check("sltu", reg_16, 32'h0);
        step(1);
        check("subu", reg_16, 32'h8);
        step(1);
        check("nor", reg_16, 32'h7);
        step(1);
        check("ori_zext", reg_16, 32'h0000_8001);
        step(1);
        check("andi_zext", reg_16, 32'h0000_FFF0);
        step(1);
        check("bad_op_r16", reg_16, 32'h0000_FFF0);
        check("bad_op_pc", pc, 32'h0040_0028);

        // stall, resume, reset during stall
        clear_prog();
        for (int i = 0; i < 8; i++) prog[i] = 32'h2610_0001;
        load_and_start();
        step(1);
        cpu_stall = 1'b1;
        step(4);
        check("stall_pc", pc, 32'h0040_0004);
        check("stall_inst", inst, 32'h2610_0001);
        check("stall_r16", reg_16, 32'h1);
        cpu_stall = 1'b0;
        step(1);
        check("resume_pc", pc, 32'h0040_0008);
        check("resume_r16", reg_16, 32'h2);
        cpu_stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("stall_rst_pc", pc, 32'h0040_0000);
        check("stall_rst_r16", reg_16, 32'h0);
        step(1);
        reset = 1'b1;
        step(1);
        check("stall_after_rst_pc", pc, 32'h0040_0000);
        cpu_stall = 1'b0;
        step(1);
        check("post_rst_r16", reg_16, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
